hub_port_tx: RTL and testbench
==============================

// Module: hub_port_tx
// PURPOSE
// - Serial transmit side of one HUB port: turns a byte stream from the HUB switching logic into the
//   single-wire line format that the port receiver decodes.
// - Per frame: 8-bit SFD 1,0,1,0,1,0,1,1 (first-sent first), then payload bytes LSB-first.
// - One bit per clk; the line idles low. One instance sits between the HUB core and each txN pin.
// PARAMETERS
// - SFD         8'b11010101  SFD pattern, sent bit[0] first (gives 1,0,1,0,1,0,1,1 on the line).
// - IFG_CYCLES  12           Idle-low cycles forced after each frame; used only with HUB_TX_IFG_EN.
// PORTS
// - clk        in   1  Port clock; one line bit per cycle.
// - reset      in   1  Synchronous, active-high reset.
// - s_data     in   8  Payload byte to send.
// - s_valid    in   1  s_data/s_last are valid.
// - s_last     in   1  Byte is the final byte of the frame.
// - s_ready    out  1  Block accepts the byte this cycle (transfer = s_valid & s_ready).
// - tx         out  1  Serial line, registered.
// - busy       out  1  High from the cycle after frame accept until the state returns to IDLE.
// - frame_done out  1  One-cycle pulse: cycle after the last payload bit.
// - underrun   out  1  One-cycle pulse: frame aborted because a byte was missing mid-frame.
// BEHAVIOUR
// - Reset values: tx=0, s_ready=0, busy=0, frame_done=0, underrun=0, state=IDLE, counters=0.
// - States:
//   - IDLE: tx=0, s_ready=1. A transfer at cycle N latches the byte and goes to SFD.
//   - SFD: 8 cycles, tx=SFD[k] at cycle N+1+k. The last SFD bit is at N+8.
//   - DATA: tx=byte[b] at cycle N+9+b, bit counter 0..7.
//   - IFG: tx=0, s_ready=0, for IFG_CYCLES cycles, then IDLE.
// - Latency: first payload byte accepted -> its bit0 on tx 9 cycles later.
// - Back-to-back bytes:
//   - In DATA, s_ready=1 only while bit7 of a non-last byte is on tx.
//   - A transfer there makes the next byte's bit0 appear on the next cycle, with no gap.
// - Frame end:
//   - After bit7 of the s_last byte, the next cycle has tx=0 and frame_done=1.
//   - The state goes to IFG (macro on) or IDLE (macro off).
// - Underrun: at bit7 of a non-last byte with s_valid=0:
//   - Next cycle tx=0, underrun=1, frame_done=0.
//   - Then the same end path as a normal frame (IFG or IDLE).
// - s_ready=0 in SFD and IFG, and in DATA except at bit7. s_valid is ignored when s_ready=0.
// - Only the latched copy of s_data/s_last is used during shifting.
// - The byte accepted in IDLE may itself carry s_last: that is a 1-byte frame.
// - Reset mid-frame: on the next edge tx=0 and state=IDLE.
//   - No frame_done or underrun pulse; the partial frame is simply truncated.
// - frame_done and underrun are mutually exclusive, never asserted in consecutive cycles for the
//   same frame.
// CONFIGURATION
// - HUB_TX_IFG_EN defined:
//   - After frame_done/underrun, IFG holds tx=0 and s_ready=0 for IFG_CYCLES cycles.
//   - busy stays high through IFG.
// - HUB_TX_IFG_EN undefined:
//   - IFG state absent; returns to IDLE directly.
//   - s_ready=1 in the frame_done cycle, so the minimum line gap between frames is 1 low cycle.
// TESTING
// - Single frame, byte 0xF0 with s_last -> tx = 1,0,1,0,1,0,1,1,0,0,0,0,1,1,1,1, then 0.
//   frame_done at accept+17.
// - Two bytes 0xA5 then 0x3C (last), second offered early:
//   - Accepted exactly at bit7 of 0xA5.
//   - Line after SFD: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with no gap.
// - Underrun: 0x55 non-last, s_valid held low -> after its bit7, tx=0 and one underrun pulse.
//   No frame_done; IDLE, or IFG when the macro is on.
// - Reset asserted at the 4th SFD bit -> tx=0 next cycle, busy=0, no pulses.
//   A new frame afterwards is sent correctly.
// - HUB_TX_IFG_EN, IFG_CYCLES=12: two 1-byte frames offered continuously.
//   - Exactly 12 low cycles after frame_done before s_ready rises.
//   - Second SFD starts 1 cycle after accept.
// - s_valid toggling with s_ready=0 during SFD/IFG -> no byte consumed; the stream order is preserved.

Source files
------------

// File: rtl/hub_port_tx.sv
// ============================================================================
// hub_port_tx
// ----------------------------------------------------------------------------
// Serial transmit side of one HUB port. Takes payload bytes from the HUB
// switching logic over a valid/ready handshake and serialises them onto a
// single idle-low wire, one bit per clock. Each frame is an 8-bit start
// frame delimiter (SFD, bit[0] first) followed by the payload bytes,
// each sent LSB-first.
//
// Optional feature macro: HUB_TX_IFG_EN
//   defined   -> after every frame end (normal or aborted) the line is held
//                low with s_ready=0 for IFG_CYCLES cycles before IDLE.
//   undefined -> no inter-frame gap state; the block returns to IDLE
//                directly and is ready again in the frame_done cycle.
//
// Parameters
//   SFD         start frame delimiter pattern, sent bit[0] first
//   IFG_CYCLES  forced idle cycles after each frame (HUB_TX_IFG_EN only)
//
// Ports
//   clk         in   port clock, one line bit per cycle
//   reset       in   synchronous active-high reset
//   s_data      in   payload byte
//   s_valid     in   s_data/s_last are valid
//   s_last      in   byte is the final byte of the frame
//   s_ready     out  byte is accepted this cycle when s_valid is high
//   tx          out  registered serial line
//   busy        out  high from the cycle after frame accept until IDLE
//   frame_done  out  one-cycle pulse after the last payload bit
//   underrun    out  one-cycle pulse when a frame is aborted for lack of data
// ============================================================================
module hub_port_tx #(
    parameter logic [7:0] SFD = 8'b11010101
`ifdef HUB_TX_IFG_EN
    ,
    parameter int unsigned IFG_CYCLES = 12
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SFD,
        ST_DATA
`ifdef HUB_TX_IFG_EN
        ,
        ST_IFG
`endif
    } state_t;

`ifdef HUB_TX_IFG_EN
    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    logic [IFG_W-1:0] r_ifgCnt;
`endif

    state_t      r_state;
    logic [7:0]  r_byte;
    logic        r_last;
    logic [2:0]  r_bitCnt;
    logic        r_ready;
    logic        r_tx;
    logic        r_busy;
    logic        r_frameDone;
    logic        r_underrun;

    logic        w_accept;
    logic [2:0]  w_nextCnt;

    assign w_accept  = s_valid & r_ready;
    assign w_nextCnt = r_bitCnt + 3'd1;

    assign s_ready    = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;
    assign underrun   = r_underrun;

    // Single registered FSM. r_bitCnt always names the bit that is currently
    // on the line (SFD bit in ST_SFD, payload bit in ST_DATA), so the value
    // loaded into r_tx at each edge is the bit at index r_bitCnt+1, or bit 0
    // of the next field when the current field ends. s_ready is computed one
    // cycle ahead so that it is high exactly while bit7 of a non-last byte
    // is on the line, letting the next byte follow with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_byte      <= 8'd0;
            r_last      <= 1'b0;
            r_bitCnt    <= 3'd0;
            r_ready     <= 1'b0;
            r_tx        <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;
`ifdef HUB_TX_IFG_EN
            r_ifgCnt    <= '0;
`endif
        end else begin
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_tx    <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_byte   <= s_data;
                        r_last   <= s_last;
                        r_tx     <= SFD[0];
                        r_bitCnt <= 3'd0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SFD;
                    end
                end

                ST_SFD: begin
                    if (r_bitCnt == 3'd7) begin
                        r_tx     <= r_byte[0];
                        r_bitCnt <= 3'd0;
                        r_state  <= ST_DATA;
                    end else begin
                        r_tx     <= SFD[w_nextCnt];
                        r_bitCnt <= w_nextCnt;
                    end
                end

                ST_DATA: begin
                    if (r_bitCnt != 3'd7) begin
                        r_tx     <= r_byte[w_nextCnt];
                        r_bitCnt <= w_nextCnt;
                        r_ready  <= (w_nextCnt == 3'd7) && !r_last;
                    end else if (w_accept) begin
                        // Next byte of the same frame follows immediately.
                        r_byte   <= s_data;
                        r_last   <= s_last;
                        r_tx     <= s_data[0];
                        r_bitCnt <= 3'd0;
                        r_ready  <= 1'b0;
                    end else begin
                        // Either the last byte finished or the source ran dry.
                        r_tx        <= 1'b0;
                        r_bitCnt    <= 3'd0;
                        r_frameDone <= r_last;
                        r_underrun  <= !r_last;
`ifdef HUB_TX_IFG_EN
                        r_ready     <= 1'b0;
                        r_ifgCnt    <= '0;
                        r_state     <= ST_IFG;
`else
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
`endif
                    end
                end

`ifdef HUB_TX_IFG_EN
                // The pulse cycle counts as gap step 0; the block leaves IFG
                // after IFG_CYCLES further low cycles with s_ready held low.
                ST_IFG: begin
                    r_tx    <= 1'b0;
                    r_ready <= 1'b0;
                    if (r_ifgCnt == IFG_W'(IFG_CYCLES)) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifgCnt <= r_ifgCnt + 1'b1;
                    end
                end
`endif

                default: begin
                    r_tx    <= 1'b0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub_port_tx.sv
// ============================================================================
// tb_hub_port_tx
// ----------------------------------------------------------------------------
// Self-checking bench for hub_port_tx. A queue-based line model predicts
// tx/s_ready/busy/frame_done/underrun every cycle; directed scenarios add
// hand-computed literal expectations for line patterns and pulse timing.
// Honours HUB_TX_IFG_EN the same way as the design.
// ============================================================================
module tb_hub_port_tx;

    localparam logic [7:0] SFD_PAT = 8'b11010101;
    localparam int REC_N = 4096;
`ifdef HUB_TX_IFG_EN
    localparam int IFG = 12;
    localparam int GAP = 13;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int vectors = 0;
    int miscompares = 0;

    hub_port_tx dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Line model: a queue of bits still to be put on the wire. A frame
    // start enqueues SFD + byte; each cycle pops one bit. When the queue is
    // empty with a frame active, the current bit is bit7 of a byte.
    // ------------------------------------------------------------------
    bit q[$];
    bit mTx, mReady, mBusy, mDone, mUnder, mActive, mByteLast;
    int mIfgLeft;
    bit modelValid = 0;

    always @(posedge clk) begin : modelStep
        bit acc;
        acc    = s_valid && mReady;
        mDone  = 0;
        mUnder = 0;
        if (reset) begin
            q.delete();
            mTx = 0; mReady = 0; mBusy = 0; mActive = 0; mByteLast = 0;
            mIfgLeft = 0;
            modelValid = 1;
        end else if (!mActive) begin
            if (mIfgLeft > 0) begin
                mIfgLeft--;
                mTx = 0; mReady = 0; mBusy = 1;
            end else if (acc) begin
                for (int i = 0; i < 8; i++) q.push_back(SFD_PAT[i]);
                for (int i = 0; i < 8; i++) q.push_back(s_data[i]);
                mByteLast = s_last;
                mTx = q.pop_front();
                mReady = 0; mBusy = 1; mActive = 1;
            end else begin
                mTx = 0; mReady = 1; mBusy = 0;
            end
        end else if (q.size() > 0) begin
            mTx = q.pop_front();
            mReady = (q.size() == 0) && !mByteLast;
            mBusy = 1;
        end else if (acc) begin
            for (int i = 0; i < 8; i++) q.push_back(s_data[i]);
            mByteLast = s_last;
            mTx = q.pop_front();
            mReady = 0;
        end else begin
            mTx = 0;
            mDone = mByteLast;
            mUnder = !mByteLast;
            mActive = 0;
`ifdef HUB_TX_IFG_EN
            mIfgLeft = IFG;
            mReady = 0; mBusy = 1;
`else
            mReady = 1; mBusy = 0;
`endif
        end
    end

    // Per-cycle compare against the model, plus a record of the line.
    logic recTx[REC_N];
    logic recDone[REC_N];
    logic recUnder[REC_N];
    logic recReady[REC_N];
    logic recBusy[REC_N];
    int sampleIdx = 0;

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("cyc_tx", tx, mTx);
            checkOutput("cyc_s_ready", s_ready, mReady);
            checkOutput("cyc_busy", busy, mBusy);
            checkOutput("cyc_frame_done", frame_done, mDone);
            checkOutput("cyc_underrun", underrun, mUnder);
        end
        if (sampleIdx < REC_N) begin
            recTx[sampleIdx]    = tx;
            recDone[sampleIdx]  = frame_done;
            recUnder[sampleIdx] = underrun;
            recReady[sampleIdx] = s_ready;
            recBusy[sampleIdx]  = busy;
        end
        sampleIdx++;
    end

    function automatic logic rdTx(int i);
        if (i < 0 || i >= REC_N) return 1'bx;
        return recTx[i];
    endfunction

    function automatic logic rdDone(int i);
        if (i < 0 || i >= REC_N) return 1'bx;
        return recDone[i];
    endfunction

    function automatic logic rdUnder(int i);
        if (i < 0 || i >= REC_N) return 1'bx;
        return recUnder[i];
    endfunction

    function automatic logic rdReady(int i);
        if (i < 0 || i >= REC_N) return 1'bx;
        return recReady[i];
    endfunction

    function automatic logic rdBusy(int i);
        if (i < 0 || i >= REC_N) return 1'bx;
        return recBusy[i];
    endfunction

    function automatic int countDone(int s, int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (rdDone(i) === 1'b1) c++;
        return c;
    endfunction

    function automatic int countUnder(int s, int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (rdUnder(i) === 1'b1) c++;
        return c;
    endfunction

    function automatic int countReady(int s, int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (rdReady(i) === 1'b1) c++;
        return c;
    endfunction

    function automatic int countBusy(int s, int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (rdBusy(i) === 1'b1) c++;
        return c;
    endfunction

    // Offers one byte and holds it until accepted; acc is the cycle index of
    // the transfer cycle, or -1 on timeout.
    task automatic applyStimulus(input logic [7:0] d, input logic l, output int acc);
        bit got = 0;
        acc = -1;
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (s_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            acc = sampleIdx - 1;
            @(posedge clk); #1;
        end else begin
            checkOutput("accept_timeout", 0, 1);
        end
        s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
    endtask

    task automatic waitUntilSample(input int idx);
        for (int n = 0; n < 500; n++) begin
            if (sampleIdx > idx) return;
            @(negedge clk); #1;
        end
        checkOutput("sample_timeout", 0, 1);
    endtask

    task automatic checkLine(input string name, input int start, input logic [15:0] pat);
        logic [15:0] got;
        if (start < 0) begin
            checkOutput(name, 32'hffff_ffff, {16'd0, pat});
            return;
        end
        waitUntilSample(start + 15);
        for (int i = 0; i < 16; i++) got[15-i] = rdTx(start + i);
        checkOutput(name, {16'd0, got}, {16'd0, pat});
    endtask

    task automatic waitIdle();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (s_ready === 1'b1 && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic printSummary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        printSummary();
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, b, f;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx", tx, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_underrun", underrun, 0);
        reset = 1'b0;

        // Single 1-byte frame 0xF0
        applyStimulus(8'hF0, 1'b1, a);
        checkLine("f0_line", a + 1, 16'hAB0F);
        waitUntilSample(a + 20);
        checkOutput("f0_done_at_17", rdDone(a + 17), 1);
        checkOutput("f0_tx_low_after", rdTx(a + 17), 0);
        checkOutput("f0_done_count", countDone(a + 1, 20), 1);
        checkOutput("f0_busy_in_frame", countBusy(a + 1, 16), 16);
        waitIdle();

        // Two bytes back to back, second offered early
        applyStimulus(8'hA5, 1'b0, a);
        applyStimulus(8'h3C, 1'b1, b);
        checkOutput("a5_accept_at_bit7", b - a, 16);
        checkLine("a5_sfd_and_first", a + 1, 16'hABA5);
        checkLine("a5_3c_payload", a + 9, 16'hA53C);
        waitUntilSample(a + 28);
        checkOutput("a5_3c_done_at_25", rdDone(a + 25), 1);
        checkOutput("a5_3c_done_count", countDone(a + 1, 28), 1);
        waitIdle();

        // Underrun: non-last byte with no follow-up
        applyStimulus(8'h55, 1'b0, a);
        checkLine("ur_line", a + 1, 16'hABAA);
        waitUntilSample(a + 20);
        checkOutput("ur_pulse_at_17", rdUnder(a + 17), 1);
        checkOutput("ur_tx_low", rdTx(a + 17), 0);
        checkOutput("ur_pulse_count", countUnder(a + 1, 20), 1);
        checkOutput("ur_no_done", countDone(a + 1, 20), 0);
        waitIdle();

        // Reset asserted while the 4th SFD bit is on the line
        applyStimulus(8'hC3, 1'b1, a);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitUntilSample(a + 30);
        checkOutput("mid_rst_sfd_head", {rdTx(a + 1), rdTx(a + 2), rdTx(a + 3), rdTx(a + 4)}, 4'b1010);
        checkOutput("mid_rst_tx_low", rdTx(a + 5), 0);
        checkOutput("mid_rst_busy_low", rdBusy(a + 5), 0);
        checkOutput("mid_rst_no_pulses", countDone(a + 1, 30) + countUnder(a + 1, 30), 0);
        applyStimulus(8'h3C, 1'b1, b);
        checkLine("post_rst_line", b + 1, 16'hAB3C);
        waitUntilSample(b + 18);
        checkOutput("post_rst_done", rdDone(b + 17), 1);
        waitIdle();

        // s_valid toggling with junk while s_ready is low
        applyStimulus(8'h12, 1'b0, a);
        for (int i = 0; i < 6; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = 8'hFF;
            s_last  = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        applyStimulus(8'h34, 1'b1, b);
        checkOutput("tog_accept_at_bit7", b - a, 16);
        checkLine("tog_payload", a + 9, 16'h482C);
        waitUntilSample(a + 28);
        checkOutput("tog_done_at_25", rdDone(a + 25), 1);
        waitIdle();

        // Two 1-byte frames offered continuously
        applyStimulus(8'h81, 1'b1, a);
        applyStimulus(8'h7E, 1'b1, b);
        f = a + 17;
        checkLine("cont_first", a + 1, 16'hAB81);
        checkOutput("cont_gap", b - f, GAP);
        checkLine("cont_second", b + 1, 16'hAB7E);
        waitUntilSample(b + 18);
        checkOutput("cont_second_done", rdDone(b + 17), 1);
`ifdef HUB_TX_IFG_EN
        checkOutput("ifg_ready_low", countReady(f, 13), 0);
        checkOutput("ifg_busy_high", countBusy(f, 13), 13);
        checkOutput("ifg_ready_rise", rdReady(f + 13), 1);
`else
        checkOutput("noifg_ready_in_done", rdReady(f), 1);
        checkOutput("noifg_busy_in_done", rdBusy(f), 0);
`endif
        waitIdle();

        repeat (5) @(posedge clk);
        #1;
        printSummary();
        $finish;
    end

endmodule
